// File: rtl/key_poll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : key_poll_pkg                                           |
// | Description : Shared state encoding and counter widths for the key   |
// |               poll master and its per-bit debouncer.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package key_poll_pkg;

    localparam int c_cnt_w  = 4;
    localparam int c_tick_w = 32;
    localparam int c_tmo_w  = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : key_debounce                                           |
// | Description : Single-bit debouncer; flips its level after a run of   |
// |               consecutive disagreeing samples and pulses the edge.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module key_debounce
    import key_poll_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sample,
    input  logic i_sample_valid,
    output logic o_state,
    output logic o_press,
    output logic o_release
);

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEBOUNCE_CNT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_state;
    logic               r_press;
    logic               r_release;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_state   <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (i_sample_valid) begin
                if (i_sample == r_state) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_last) begin
                    // Active-low keys: falling level is a press.
                    r_state   <= i_sample;
                    r_cnt     <= '0;
                    r_press   <= ~i_sample;
                    r_release <= i_sample;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_poll_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : key_poll_master                                        |
// | Description : Avalon-MM read master polling a push-button PIO and    |
// |               emitting debounced key level plus press/release pulses.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module key_poll_master
    import key_poll_pkg::*;
#(
    parameter int                WIDTH        = 2,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] PIO_BASE     = '0,
    parameter int                POLL_DIV     = 50000,
    parameter int                DEBOUNCE_CNT = 4,
    parameter int                TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [WIDTH-1:0]  key_state,
    output logic [WIDTH-1:0]  key_press,
    output logic [WIDTH-1:0]  key_release,
    output logic              timeout_err
);

    state_t              r_state;
    logic [c_tick_w-1:0] r_tick;
    logic [c_tmo_w-1:0]  r_tmo;
    logic                r_read;
    logic                r_tmo_err;

    logic w_tick;
    logic w_accept;
    logic w_expire;
    logic w_sample_valid;

    assign w_tick   = (r_tick == c_tick_w'(POLL_DIV - 1));
    assign w_accept = (r_state == c_st_req) && !avm_waitrequest;
    assign w_expire = (r_tmo == c_tmo_w'(TIMEOUT - 1));

    // Data is only meaningful for our own outstanding read; stray valids in IDLE are dropped.
    assign w_sample_valid = avm_readdatavalid && (w_accept || (r_state == c_st_wait));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= '0;
        end else if (w_tick) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_read    <= 1'b0;
            r_tmo     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_tick) begin
                        r_state <= c_st_req;
                        r_read  <= 1'b1;
                        r_tmo   <= '0;
                    end
                end
                c_st_req: begin
                    if (w_accept) begin
                        r_read  <= 1'b0;
                        r_tmo   <= r_tmo + 1'b1;
                        r_state <= avm_readdatavalid ? c_st_idle : c_st_wait;
                    end else if (w_expire) begin
                        r_read    <= 1'b0;
                        r_state   <= c_st_idle;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_st_wait: begin
                    if (avm_readdatavalid) begin
                        r_state <= c_st_idle;
                    end else if (w_expire) begin
                        r_state   <= c_st_idle;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_debounce (
            .clk            (clk),
            .reset          (reset),
            .i_sample       (avm_readdata[gi]),
            .i_sample_valid (w_sample_valid),
            .o_state        (key_state[gi]),
            .o_press        (key_press[gi]),
            .o_release      (key_release[gi])
        );
    end

    if (WIDTH < 32) begin : g_unused_data
        logic w_unused_data;
        assign w_unused_data = &{1'b0, avm_readdata[31:WIDTH]};
    end

    assign avm_address = PIO_BASE;
    assign avm_read    = r_read;
    assign timeout_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_key_poll_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_key_poll_master                                     |
// | Description : Directed bench with an L=1 Avalon responder and a      |
// |               scoreboard of expected debounce results per sample.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_key_poll_master;

    localparam int          WIDTH        = 2;
    localparam int          ADDR_W       = 32;
    localparam logic [31:0] PIO_BASE     = 32'h0000_0040;
    localparam int          POLL_DIV     = 10;
    localparam int          DEBOUNCE_CNT = 4;
    localparam int          TIMEOUT      = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic [WIDTH-1:0]  key_state;
    logic [WIDTH-1:0]  key_press;
    logic [WIDTH-1:0]  key_release;
    logic              timeout_err;

    key_poll_master #(
        .WIDTH        (WIDTH),
        .ADDR_W       (ADDR_W),
        .PIO_BASE     (PIO_BASE),
        .POLL_DIV     (POLL_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .key_state         (key_state),
        .key_press         (key_press),
        .key_release       (key_release),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int n_samples = 0;
    int n_acc   = 0;

    bit               respond;
    bit               vld_drv;
    logic [WIDTH-1:0] def_data;
    logic [WIDTH-1:0] data_q [$];
    logic [5:0]       sb_q [$];
    logic [WIDTH-1:0] press_acc;
    logic [WIDTH-1:0] rel_acc;

    // Reference debouncer state, reset alongside the DUT.
    logic [WIDTH-1:0] m_state;
    int               m_cnt [WIDTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = '1;
        for (int b = 0; b < WIDTH; b++) m_cnt[b] = 0;
    endtask

    task automatic drive_sample();
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] ep;
        logic [WIDTH-1:0] er;
        logic [31:0]      rnd;
        d   = (data_q.size() != 0) ? data_q.pop_front() : def_data;
        rnd = $urandom();
        avm_readdata      = {rnd[31:WIDTH], d};
        avm_readdatavalid = 1'b1;
        vld_drv           = 1'b1;
        n_samples++;
        ep = '0;
        er = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (d[b] == m_state[b]) begin
                m_cnt[b] = 0;
            end else if (m_cnt[b] + 1 == DEBOUNCE_CNT) begin
                m_state[b] = d[b];
                m_cnt[b]   = 0;
                if (d[b] == 1'b0) ep[b] = 1'b1;
                else              er[b] = 1'b1;
            end else begin
                m_cnt[b] = m_cnt[b] + 1;
            end
        end
        sb_q.push_back({m_state, ep, er});
    endtask

    task automatic cyc();
        logic       acc;
        logic [5:0] e;
        acc = (avm_read === 1'b1) && (avm_waitrequest === 1'b0);
        @(posedge clk);
        #1;
        cyc_n++;
        if (acc) n_acc++;
        press_acc = press_acc | key_press;
        rel_acc   = rel_acc | key_release;
        if (vld_drv) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_empty: observed no entry expected one");
            end else begin
                e = sb_q.pop_front();
                chk("sample_result", 64'({key_state, key_press, key_release}), 64'(e));
            end
        end else begin
            chk("no_pulse", 64'({key_press, key_release}), 64'(0));
        end
        vld_drv           = 1'b0;
        avm_readdatavalid = 1'b0;
        if (acc && respond) drive_sample();
    endtask

    task automatic wait_read_rise(input int max, output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            prev = avm_read;
            cyc();
            if (avm_read === 1'b1 && prev !== 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_samples(input int n);
        int start;
        int i;
        start = n_samples;
        i     = 0;
        while ((n_samples - start) < n && i < (n + 2) * POLL_DIV) begin
            cyc();
            i++;
        end
        chk("samples_arrived", 64'(n_samples - start), 64'(n));
        cyc();
    endtask

    initial begin
        bit ok;
        bit seen;
        int r0;

        reset             = 1'b1;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 32'h3;
        avm_readdatavalid = 1'b0;
        respond           = 1'b1;
        vld_drv           = 1'b0;
        def_data          = 2'b11;
        press_acc         = '0;
        rel_acc           = '0;
        model_reset();

        // Reset values
        repeat (3) cyc();
        chk("rst_read",    64'(avm_read),    64'(0));
        chk("rst_state",   64'(key_state),   64'(2'b11));
        chk("rst_tmo_err", 64'(timeout_err), 64'(0));
        chk("rst_address", 64'(avm_address), 64'(PIO_BASE));
        reset = 1'b0;

        // Idle interconnect: one-cycle read every POLL_DIV cycles
        wait_read_rise(POLL_DIV + 2, ok);
        chk("first_read", 64'(ok), 64'(1));
        r0 = cyc_n;
        cyc();
        chk("read_width", 64'(avm_read), 64'(0));
        wait_read_rise(POLL_DIV + 2, ok);
        chk("second_read", 64'(ok), 64'(1));
        chk("poll_period", 64'(cyc_n - r0), 64'(POLL_DIV));
        repeat (40) cyc();
        chk("idle_state", 64'(key_state), 64'(2'b11));
        chk("idle_press", 64'(press_acc), 64'(0));
        chk("idle_rel",   64'(rel_acc),   64'(0));

        // Bit 0 held low, then restored
        def_data = 2'b10;
        wait_samples(3);
        chk("press_not_yet", 64'(key_state), 64'(2'b11));
        wait_samples(1);
        chk("press_state", 64'(key_state), 64'(2'b10));
        chk("press_seen",  64'(press_acc), 64'(2'b01));
        def_data  = 2'b11;
        press_acc = '0;
        wait_samples(4);
        chk("release_state", 64'(key_state), 64'(2'b11));
        chk("release_seen",  64'(rel_acc),   64'(2'b01));
        chk("release_nopress", 64'(press_acc), 64'(0));

        // Bounce: interruptions must restart the count
        press_acc = '0;
        rel_acc   = '0;
        data_q    = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10};
        wait_samples(8);
        chk("bounce_state", 64'(key_state), 64'(2'b11));
        chk("bounce_press", 64'(press_acc), 64'(0));
        chk("bounce_rel",   64'(rel_acc),   64'(0));

        // Waitrequest stall of 10 cycles with a tick falling inside it
        wait_read_rise(POLL_DIV + 2, ok);
        chk("stall_read", 64'(ok), 64'(1));
        avm_waitrequest = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_read_hold", 64'(avm_read),    64'(1));
            chk("stall_addr_hold", 64'(avm_address), 64'(PIO_BASE));
            cyc();
        end
        avm_waitrequest = 1'b0;
        chk("stall_read_end", 64'(avm_read), 64'(1));
        repeat (8) cyc();
        chk("stall_one_txn", 64'(n_acc), 64'(1));

        // No data returned: timeout pulse, then polling resumes
        respond = 1'b0;
        wait_read_rise(POLL_DIV + 2, ok);
        chk("tmo_read", 64'(ok), 64'(1));
        r0   = cyc_n;
        seen = 1'b0;
        for (int i = 0; i < 3 * TIMEOUT && !seen; i++) begin
            cyc();
            if (timeout_err === 1'b1) seen = 1'b1;
        end
        chk("tmo_seen",    64'(seen),        64'(1));
        chk("tmo_latency", 64'(cyc_n - r0),  64'(TIMEOUT));
        cyc();
        chk("tmo_width",   64'(timeout_err), 64'(0));
        wait_read_rise(POLL_DIV + 2, ok);
        chk("tmo_next_read", 64'(ok), 64'(1));
        respond = 1'b1;
        repeat (4) cyc();

        // Reset during WAIT with late data afterwards
        def_data = 2'b10;
        wait_samples(3);
        chk("pre_rst_state", 64'(key_state), 64'(2'b11));
        respond = 1'b0;
        wait_read_rise(POLL_DIV + 2, ok);
        chk("rst_wait_read", 64'(ok), 64'(1));
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("mid_rst_read",  64'(avm_read),    64'(0));
        chk("mid_rst_state", 64'(key_state),   64'(2'b11));
        chk("mid_rst_press", 64'(key_press),   64'(0));
        chk("mid_rst_tmo",   64'(timeout_err), 64'(0));
        reset = 1'b0;
        model_reset();
        cyc();
        avm_readdata      = 32'h0000_0002;
        avm_readdatavalid = 1'b1;
        cyc();
        chk("late_data_state", 64'(key_state), 64'(2'b11));
        respond   = 1'b1;
        press_acc = '0;
        wait_samples(3);
        chk("post_rst_count", 64'(key_state), 64'(2'b11));
        wait_samples(1);
        chk("post_rst_press", 64'(key_state), 64'(2'b10));
        chk("post_rst_pulse", 64'(press_acc), 64'(2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_poll_master.md
# key_poll_master

Avalon-MM read initiator that periodically polls a push-button input PIO, debounces each bit over consecutive samples, and emits a debounced key state plus one-cycle press/release pulses. Sits on the Nios system interconnect as a small master beside the CPU. Keypad events reach fabric logic without software polling.

## Interface
Parameters:
- `WIDTH`, 2: number of key bits taken from `readdata[WIDTH-1:0]`.
- `ADDR_W`, 32: master byte-address width.
- `PIO_BASE`, 0: byte address of the PIO data register (offset 0).
- `POLL_DIV`, 50000: clock cycles between poll ticks (≥ 4).
- `DEBOUNCE_CNT`, 4: consecutive disagreeing samples needed to change a debounced bit (1–15).
- `TIMEOUT`, 64: cycles to wait for `readdatavalid` before abandoning a read.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `avm_address` out ADDR_W: constant `PIO_BASE`.
- `avm_read` out 1: read request. Held until accepted.
- `avm_waitrequest` in 1: interconnect stall.
- `avm_readdata` in 32: returned data.
- `avm_readdatavalid` in 1: `avm_readdata` valid this cycle.
- `key_state` out WIDTH: debounced level. Keys are active-low, so 1 = released.
- `key_press` out WIDTH: one-cycle pulse per bit on a debounced 1→0 transition.
- `key_release` out WIDTH: one-cycle pulse per bit on a debounced 0→1 transition.
- `timeout_err` out 1: one-cycle pulse when a read is abandoned.

## Operation
- Tick counter counts 0..POLL_DIV-1 and wraps. The tick fires when the count equals POLL_DIV-1.
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ on tick.
  - REQ: `avm_read`=1. Leave REQ on the first cycle with `avm_waitrequest`=0, which completes the request handshake.
  - REQ → IDLE directly if `avm_readdatavalid` is seen in the acceptance cycle.
  - Otherwise REQ → WAIT.
  - WAIT → IDLE on `avm_readdatavalid`.
  - WAIT → IDLE on timeout, with a `timeout_err` pulse.
- Timeout counter clears on entry to REQ and counts in REQ and WAIT. Expiry occurs when it reaches TIMEOUT. Expiry in REQ also drops `avm_read`.
- A tick arriving outside IDLE is dropped, not queued.
- `readdatavalid` while in IDLE is ignored.
- Debounce, per bit i, on each valid sample s = `avm_readdata[i]`:
  - If s == `key_state[i]`: clear cnt[i].
  - Else if cnt[i]+1 == DEBOUNCE_CNT: toggle `key_state[i]`, clear cnt[i], and pulse press or release.
  - Else: increment cnt[i].
- cnt width is 4 bits.
- `avm_readdata` bits at WIDTH and above are ignored.
- Reset values: `avm_read`=0, FSM=IDLE, tick and timeout counters=0, all cnt=0, `key_state`=all ones, `key_press`=0, `key_release`=0, `timeout_err`=0.
- Reset asserted mid-transaction:
  - `avm_read` drops on the next edge.
  - Any later `readdatavalid` is discarded, because the FSM is in IDLE.

## Timing
- All outputs are registered.
- `avm_read` rises one cycle after the tick cycle.
- With zero waitrequest and fixed read latency L, the sample is registered on the edge of the `readdatavalid` cycle. `key_state` and the pulses change on that same edge.
- Detection latency of a stable change is DEBOUNCE_CNT polls. The tick stream may also add one dropped-tick delay.
- Pulses are exactly one cycle wide. Multiple bits may pulse in the same cycle.
- While `avm_waitrequest`=1, `avm_read` and `avm_address` hold steady.

## Structure
- Package `key_poll_pkg`:
  - FSM state enum (IDLE/REQ/WAIT).
  - Counter-width localparams (tick, timeout, cnt).
- Sub-module `key_debounce`: one per key bit, generated WIDTH times.
  - Inputs: sample, sample_valid.
  - Outputs: state, press, release.
  - Holds cnt and the reset-to-1 state.
- The top holds the tick counter, the FSM and the timeout counter.

## Test plan
- Reset, then idle interconnect (waitrequest=0, L=1, readdata=3): `avm_read` is a 1-cycle pulse every POLL_DIV cycles; `key_state`=2'b11; no pulses.
- Bit 0 driven low permanently (readdata=2): on the 4th valid sample `key_state`=2'b10 with `key_press`=2'b01 for one cycle. Restoring readdata=3 gives a `key_release` pulse after 4 samples.
- Bounce pattern 2,3,2,2,3 on successive samples: `key_state` never changes and no pulses occur. Counter reset is confirmed.
- `avm_waitrequest` held high for 10 cycles: `avm_read` and `avm_address`=PIO_BASE are stable throughout. A tick during the stall is dropped, giving exactly one transaction.
- No `readdatavalid` is ever returned: `timeout_err` pulses TIMEOUT cycles after request start, the FSM returns to IDLE, and the next tick issues a new read.
- `reset` asserted while in WAIT, with `readdatavalid` arriving 2 cycles later: the outputs show reset values and the late data does not alter `key_state` or the counters.
